axi_rd_arbiter: RTL and testbench

Round-robin arbiter that shares the single AXI4 read channel of the DDR port between N_MASTERS read masters (CPU cache refill, Versat feature-map/weight DMA). It sits between the masters and the system-level `m_axi_ar*`/`m_axi_r*` DDR pins and allows exactly one burst in flight. It tracks beats against `arlen` and flags protocol mismatches.

---
 rtl/axi_rd_arbiter.sv | 132 +++++++++++++
 tb/tb_axi_rd_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Round-robin AXI4 read-channel arbiter: N masters share one DDR read port, one burst in flight.
// Define AXI_RD_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module axi_rd_arbiter #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_MASTERS-1:0]      m_arvalid,
    input  logic [N_MASTERS*ADDR_W-1:0] m_araddr,
    input  logic [N_MASTERS*8-1:0]    m_arlen,
    output logic [N_MASTERS-1:0]      m_arready,
    output logic [N_MASTERS-1:0]      m_rvalid,
    input  logic [N_MASTERS-1:0]      m_rready,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      m_rlast,
    output logic                      s_arvalid,
    output logic [ADDR_W-1:0]         s_araddr,
    output logic [7:0]                s_arlen,
    input  logic                      s_arready,
    input  logic                      s_rvalid,
    output logic                      s_rready,
    input  logic [DATA_W-1:0]         s_rdata,
    input  logic                      s_rlast,
    output logic [N_MASTERS-1:0]      gnt,
    output logic                      len_err
);

    localparam int unsigned PTR_W = $clog2(N_MASTERS);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_t;

    state_t           state;
    logic [7:0]       beat_cnt;
    logic [7:0]       len_q;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] win_idx;
    logic             win_valid;
    logic             beat;
    int unsigned      start;
    int unsigned      idx;

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    always_comb start = 0;
`else
    logic [PTR_W-1:0] rr_ptr;
    always_comb start = 32'(rr_ptr);
`endif

    // Scan from the highest offset down so the lowest offset from start wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            idx = (start + unsigned'(k)) % N_MASTERS;
            if (m_arvalid[idx[PTR_W-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_idx  = '0;
        s_araddr = '0;
        s_arlen  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (gnt[i]) begin
                gnt_idx  = PTR_W'(i);
                s_araddr = m_araddr[i*ADDR_W +: ADDR_W];
                s_arlen  = m_arlen[i*8 +: 8];
            end
        end
    end

    always_comb begin
        s_arvalid = (state == StAddr) && |(m_arvalid & gnt);
        m_arready = (state == StAddr && s_arready) ? gnt : '0;
        s_rready  = (state == StData) && |(m_rready & gnt);
        m_rvalid  = (state == StData && s_rvalid) ? gnt : '0;
        m_rdata   = (state == StData) ? s_rdata : '0;
        m_rlast   = (state == StData) ? s_rlast : 1'b0;
        beat      = s_rvalid && s_rready;
        len_err   = beat && (s_rlast != (beat_cnt == len_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            gnt      <= '0;
            beat_cnt <= '0;
            len_q    <= '0;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
            rr_ptr   <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (win_valid) begin
                        gnt          <= '0;
                        gnt[win_idx] <= 1'b1;
                        state        <= StAddr;
                    end
                end
                StAddr: begin
                    // A master dropping arvalid here keeps its grant; nothing else may win.
                    if (s_arvalid && s_arready) begin
                        len_q    <= s_arlen;
                        beat_cnt <= '0;
                        state    <= StData;
                    end
                end
                StData: begin
                    if (beat) begin
                        beat_cnt <= (beat_cnt == 8'hff) ? 8'hff : beat_cnt + 8'd1;
                        if (s_rlast) begin
                            state <= StIdle;
                            gnt   <= '0;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
                            rr_ptr <= PTR_W'((32'(gnt_idx) + 1) % N_MASTERS);
`endif
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter: masters and DDR are driven from a transaction-level model
// whose expected outputs are compared every cycle.
module tb_axi_rd_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_arvalid;
    logic [N*AW-1:0] m_araddr;
    logic [N*8-1:0]  m_arlen;
    logic [N-1:0]    m_arready;
    logic [N-1:0]    m_rvalid;
    logic [N-1:0]    m_rready;
    logic [DW-1:0]   m_rdata;
    logic            m_rlast;
    logic            s_arvalid;
    logic [AW-1:0]   s_araddr;
    logic [7:0]      s_arlen;
    logic            s_arready;
    logic            s_rvalid;
    logic            s_rready;
    logic [DW-1:0]   s_rdata;
    logic            s_rlast;
    logic [N-1:0]    gnt;
    logic            len_err;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rlast(m_rlast),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rlast(s_rlast),
        .gnt(gnt), .len_err(len_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    // Master-side request state.
    bit         pend [N];
    logic [31:0] req_addr [N];
    logic [7:0]  req_len [N];

    // Arbiter reference: owner -1 means no grant; addr phase until the AR handshake.
    int own   = -1;
    bit aphase = 0;
    int ptr   = 0;
    int cnt   = 0;
    int lenq  = 0;

    // DDR model: which beat carries rlast (normally beat len, sometimes deliberately wrong).
    bit ddr_active = 0;
    int ddr_beat   = 0;
    int ddr_last_at = 0;

    initial begin
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_arready;
        logic [N-1:0]  e_rvalid;
        logic          e_arvalid;
        logic [31:0]   e_araddr;
        logic [7:0]    e_arlen;
        logic          e_rready;
        logic          data_ph;
        logic          e_beat;
        logic          e_err;
        bit            found;

        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            req_addr[i] = '0;
            req_len[i] = '0;
        end
        rst = 1'b1;
        m_rready = '0;
        s_arready = 1'b0;
        s_rvalid = 1'b0;
        s_rdata = '0;
        s_rlast = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst = (cyc < 2) || ($urandom_range(0, 399) == 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) != 0) begin
                    pend[i]     = 1;
                    req_addr[i] = $urandom & 32'hffff_fffc;
                    req_len[i]  = 8'($urandom_range(0, 9));
                end
                m_rready[i] = ($urandom_range(0, 3) != 0);
                m_arvalid[i] = pend[i];
                m_araddr[i*AW +: AW] = req_addr[i];
                m_arlen[i*8 +: 8] = req_len[i];
            end
            s_arready = 1'($urandom_range(0, 1));
            s_rvalid  = ddr_active && ($urandom_range(0, 2) != 0);
            s_rdata   = $urandom;
            s_rlast   = s_rvalid ? (ddr_beat == ddr_last_at) : 1'($urandom_range(0, 1));
            #1;

            e_gnt = '0;
            if (own >= 0) e_gnt[own] = 1'b1;
            data_ph   = (own >= 0) && !aphase;
            e_arvalid = (own >= 0) && aphase && m_arvalid[own];
            e_araddr  = (own >= 0) ? req_addr[own] : 32'h0;
            e_arlen   = (own >= 0) ? req_len[own] : 8'h0;
            e_arready = ((own >= 0) && aphase && s_arready) ? e_gnt : '0;
            e_rready  = data_ph && m_rready[own];
            e_rvalid  = (data_ph && s_rvalid) ? e_gnt : '0;
            e_beat    = data_ph && s_rvalid && m_rready[own];
            e_err     = e_beat && (s_rlast != (cnt == lenq));

            if (cyc > 0) begin
                check("gnt", 64'(gnt), 64'(e_gnt));
                check("s_arvalid", 64'(s_arvalid), 64'(e_arvalid));
                check("s_araddr", 64'(s_araddr), 64'(e_araddr));
                check("s_arlen", 64'(s_arlen), 64'(e_arlen));
                check("m_arready", 64'(m_arready), 64'(e_arready));
                check("s_rready", 64'(s_rready), 64'(e_rready));
                check("m_rvalid", 64'(m_rvalid), 64'(e_rvalid));
                check("m_rdata", 64'(m_rdata), data_ph ? 64'(s_rdata) : 64'h0);
                check("m_rlast", 64'(m_rlast), data_ph ? 64'(s_rlast) : 64'h0);
                check("len_err", 64'(len_err), 64'(e_err));
            end

            if (rst) begin
                own = -1; aphase = 0; ptr = 0; cnt = 0; lenq = 0;
                ddr_active = 0;
            end else if (own < 0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (ptr + k) % N;
                    if (!found && pend[j]) begin
                        found = 1;
                        own = j;
                        aphase = 1;
                    end
                end
            end else if (aphase) begin
                if (e_arvalid && s_arready) begin
                    aphase = 0;
                    lenq = int'(req_len[own]);
                    cnt = 0;
                    pend[own] = 0;
                    ddr_active = 1;
                    ddr_beat = 0;
                    ddr_last_at = ($urandom_range(0, 5) == 0) ?
                                  int'($urandom_range(0, lenq + 2)) : lenq;
                end
            end else if (e_beat) begin
                cnt = (cnt == 255) ? 255 : cnt + 1;
                ddr_beat++;
                if (s_rlast) begin
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
                    ptr = (own + 1) % N;
`endif
                    own = -1;
                    ddr_active = 0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
